// File: rtl/cmp_sort_pkg.sv
// Shared types and sizing helpers for the comparator-driven bubble sorter.
package cmp_sort_pkg;

  typedef enum logic [1:0] {LOAD, SORT, OUT} sort_state_t;

  localparam int DATA_W = 4;

  // Wide enough to hold the worst-case swap total N*(N-1)/2.
  function automatic int swap_cnt_w(input int n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/cmp_sort_sequencer_cmp.sv
// 4-bit magnitude comparator; the only data compare used by the sorter.
module comparator_4Bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       lesser,
  output logic       greater,
  output logic       equal
);

  assign lesser  = (a < b);
  assign greater = (a > b);
  assign equal   = (a == b);

endmodule

// File: rtl/cmp_sort_sequencer.sv
// Loads N 4-bit values, bubble-sorts them in place one compare-and-swap per
// cycle through a shared comparator, then streams them out in order.
module cmp_sort_sequencer
  import cmp_sort_pkg::*;
#(
  parameter int N       = 4,
  parameter bit DESCEND = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic [swap_cnt_w(N)-1:0] swap_count,
  output sort_state_t              dbg_state
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SC_W = swap_cnt_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

  sort_state_t       r_state;
  logic [DATA_W-1:0] r_mem [N];
  logic [IW-1:0]     r_wr_idx;
  logic [IW-1:0]     r_rd_idx;
  logic [IW-1:0]     r_pass;
  logic [IW-1:0]     r_i;
  logic              r_pass_swapped;
  logic [SC_W-1:0]   r_swap_count;

  logic [IW-1:0]     w_i_nxt;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_lt;
  logic              w_gt;
  logic              w_eq;
  logic              w_do_swap;
  logic              w_pass_any;
  logic              w_pass_end;

  assign w_i_nxt = r_i + IW'(1);
  assign w_a     = r_mem[r_i];
  assign w_b     = r_mem[w_i_nxt];

  comparator_4Bit u_cmp (
    .a       (w_a),
    .b       (w_b),
    .lesser  (w_lt),
    .greater (w_gt),
    .equal   (w_eq)
  );

  // Equal neighbours never swap, which keeps the sort stable.
  assign w_do_swap  = !w_eq && (DESCEND ? w_lt : w_gt);
  assign w_pass_any = r_pass_swapped || w_do_swap;
  assign w_pass_end = (int'(r_i) + int'(r_pass)) >= (N - 2);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready is a pure function of state, never of the partner's valid.
  assign in_ready   = (r_state == LOAD);
  assign out_valid  = (r_state == OUT);
  assign out_data   = r_mem[r_rd_idx];
  assign out_last   = (r_state == OUT) && (r_rd_idx == LAST_IDX);
  assign busy       = (r_state != LOAD);
  assign swap_count = r_swap_count;
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= LOAD;
      r_wr_idx       <= '0;
      r_rd_idx       <= '0;
      r_pass         <= '0;
      r_i            <= '0;
      r_pass_swapped <= 1'b0;
      r_swap_count   <= '0;
      for (int k = 0; k < N; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid && in_ready) begin
            r_mem[r_wr_idx] <= in_data;
            if (r_wr_idx == '0) begin
              r_swap_count <= '0;
            end
            if (r_wr_idx == LAST_IDX) begin
              r_state        <= SORT;
              r_wr_idx       <= '0;
              r_pass         <= '0;
              r_i            <= '0;
              r_pass_swapped <= 1'b0;
            end else begin
              r_wr_idx <= r_wr_idx + IW'(1);
            end
          end
        end

        SORT: begin
          if (w_do_swap) begin
            r_mem[r_i]     <= w_b;
            r_mem[w_i_nxt] <= w_a;
            r_swap_count   <= r_swap_count + SC_W'(1);
          end
          // A pass with no swap means the buffer is already ordered.
          if (!w_pass_end) begin
            r_i            <= w_i_nxt;
            r_pass_swapped <= w_pass_any;
          end else if (!w_pass_any || (r_pass == LAST_PASS)) begin
            r_state <= OUT;
          end else begin
            r_pass         <= r_pass + IW'(1);
            r_i            <= '0;
            r_pass_swapped <= 1'b0;
          end
        end

        OUT: begin
          if (out_valid && out_ready) begin
            if (r_rd_idx == LAST_IDX) begin
              r_state  <= LOAD;
              r_rd_idx <= '0;
            end else begin
              r_rd_idx <= r_rd_idx + IW'(1);
            end
          end
        end

        default: r_state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sort_sequencer.sv
// Bench for cmp_sort_sequencer: ascending and descending instances checked
// against an inversion-count model of bubble sort with early exit.
module tb_cmp_sort_sequencer;
  import cmp_sort_pkg::*;

  localparam int NB  = 4;
  localparam int SCW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;
  logic       cur;

  logic           in_ready0, out_valid0, out_last0, busy0;
  logic           in_ready1, out_valid1, out_last1, busy1;
  logic [3:0]     out_data0, out_data1;
  logic [SCW-1:0] swap_count0, swap_count1;
  sort_state_t    dbg_state0, dbg_state1;

  logic           w_in_ready, w_out_valid, w_out_last, w_busy;
  logic [3:0]     w_out_data;
  logic [SCW-1:0] w_swap_count;
  sort_state_t    w_dbg_state;

  cmp_sort_sequencer #(.N(NB), .DESCEND(1'b0)) u_dut_asc (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid & ~cur),
    .in_ready   (in_ready0),
    .in_data    (in_data),
    .out_valid  (out_valid0),
    .out_ready  (out_ready & ~cur),
    .out_data   (out_data0),
    .out_last   (out_last0),
    .busy       (busy0),
    .swap_count (swap_count0),
    .dbg_state  (dbg_state0)
  );

  cmp_sort_sequencer #(.N(NB), .DESCEND(1'b1)) u_dut_desc (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid & cur),
    .in_ready   (in_ready1),
    .in_data    (in_data),
    .out_valid  (out_valid1),
    .out_ready  (out_ready & cur),
    .out_data   (out_data1),
    .out_last   (out_last1),
    .busy       (busy1),
    .swap_count (swap_count1),
    .dbg_state  (dbg_state1)
  );

  assign w_in_ready   = cur ? in_ready1   : in_ready0;
  assign w_out_valid  = cur ? out_valid1  : out_valid0;
  assign w_out_last   = cur ? out_last1   : out_last0;
  assign w_busy       = cur ? busy1       : busy0;
  assign w_out_data   = cur ? out_data1   : out_data0;
  assign w_swap_count = cur ? swap_count1 : swap_count0;
  assign w_dbg_state  = cur ? dbg_state1  : dbg_state0;

  // ---------------- scoreboard ----------------
  int         n_checks;
  int         n_fail;
  logic [3:0] exp_q[$];
  int         exp_swaps;
  int         exp_lat;
  logic [3:0] vec [NB];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bubble sort swaps equal the inversion count; passes that still swap equal
  // the largest number of out-of-order predecessors of any element.
  task automatic build_model(input logic [3:0] v[NB], input bit desc);
    int lmax;
    int inv;
    int passes;
    lmax = 0;
    inv  = 0;
    exp_q.delete();
    for (int j = 0; j < NB; j++) begin
      int left;
      int pos;
      left = 0;
      for (int i = 0; i < j; i++) begin
        if (desc ? (v[i] < v[j]) : (v[i] > v[j])) left++;
      end
      inv += left;
      if (left > lmax) lmax = left;
      pos = exp_q.size();
      for (int k = 0; k < exp_q.size(); k++) begin
        if (pos == exp_q.size() && (desc ? (exp_q[k] < v[j]) : (exp_q[k] > v[j]))) pos = k;
      end
      exp_q.insert(pos, v[j]);
    end
    passes = (lmax + 1 < NB - 1) ? lmax + 1 : NB - 1;
    exp_lat = 1;
    for (int p = 0; p < passes; p++) exp_lat += NB - 1 - p;
    exp_swaps = inv;
  endtask

  // ---------------- drivers ----------------
  task automatic load_batch(input string name, input logic [3:0] v[NB]);
    for (int j = 0; j < NB; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[j];
      check_eq({name, "/in_ready"}, 32'(w_in_ready), 32'd1);
      @(posedge clk);
    end
  endtask

  task automatic run_batch(input string name, input logic [3:0] v[NB], input bit desc, input bit bp);
    int  cyc;
    int  seen;
    int  hold;
    bit  got_valid;
    cur = desc;
    out_ready = 1'b0;
    build_model(v, desc);
    load_batch(name, v);

    cyc = 0;
    got_valid = 1'b0;
    while (!got_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'hF;
      if (cyc == 1) begin
        check_eq({name, "/busy_sort"}, 32'(w_busy), 32'd1);
        check_eq({name, "/in_ready_sort"}, 32'(w_in_ready), 32'd0);
        check_eq({name, "/state_sort"}, 32'(w_dbg_state), 32'(SORT));
      end
      got_valid = w_out_valid;
    end
    check_eq({name, "/latency"}, got_valid ? cyc : 999, exp_lat);
    check_eq({name, "/swaps_out"}, 32'(w_swap_count), exp_swaps);
    if (!got_valid) exp_q.delete();

    seen = 0;
    hold = 0;
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      check_eq({name, "/out_valid"}, 32'(w_out_valid), 32'd1);
      check_eq({name, "/out_data"}, 32'(w_out_data), 32'(exp_q[0]));
      check_eq({name, "/out_last"}, 32'(w_out_last), 32'(exp_q.size() == 1));
      if (bp && seen == 2 && hold < 3) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'hF;
      if (out_ready) begin
        void'(exp_q.pop_front());
        seen++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check_eq({name, "/drain_done"}, 32'(exp_q.size()), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq({name, "/in_ready_after"}, 32'(w_in_ready), 32'd1);
    check_eq({name, "/out_valid_after"}, 32'(w_out_valid), 32'd0);
    check_eq({name, "/busy_after"}, 32'(w_busy), 32'd0);
    check_eq({name, "/swaps_final"}, 32'(w_swap_count), exp_swaps);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    cur       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("reset/in_ready", 32'(in_ready0), 32'd1);
    check_eq("reset/out_valid", 32'(out_valid0), 32'd0);
    check_eq("reset/out_last", 32'(out_last0), 32'd0);
    check_eq("reset/busy", 32'(busy0), 32'd0);
    check_eq("reset/out_data", 32'(out_data0), 32'd0);
    check_eq("reset/swaps", 32'(swap_count0), 32'd0);
    check_eq("reset/state", 32'(dbg_state0), 32'(LOAD));
    check_eq("reset/in_ready_d", 32'(in_ready1), 32'd1);

    vec = '{4'd9, 4'd7, 4'd3, 4'd1};
    run_batch("reverse", vec, 1'b0, 1'b0);
    vec = '{4'd2, 4'd5, 4'd8, 4'd15};
    run_batch("sorted", vec, 1'b0, 1'b0);
    vec = '{4'd5, 4'd5, 4'd0, 4'd5};
    run_batch("dups", vec, 1'b0, 1'b0);
    vec = '{4'd9, 4'd7, 4'd3, 4'd1};
    run_batch("backpressure", vec, 1'b0, 1'b1);

    cur = 1'b0;
    vec = '{4'd9, 4'd7, 4'd3, 4'd1};
    load_batch("abort", vec);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort/in_ready", 32'(in_ready0), 32'd1);
    check_eq("abort/out_valid", 32'(out_valid0), 32'd0);
    check_eq("abort/busy", 32'(busy0), 32'd0);
    check_eq("abort/swaps", 32'(swap_count0), 32'd0);
    vec = '{4'd4, 4'd0, 4'd15, 4'd8};
    run_batch("after_reset", vec, 1'b0, 1'b0);

    vec = '{4'd1, 4'd9, 4'd3, 4'd7};
    run_batch("descend", vec, 1'b1, 1'b0);

    for (int it = 0; it < 12; it++) begin
      for (int j = 0; j < NB; j++) begin
        vec[j] = (it % 2 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      end
      run_batch($sformatf("rand%0d", it), vec, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
